if_id_pipe: RTL
===============

// Module: if_id_pipe
// PURPOSE
//  IF/ID pipeline register: directly downstream of the PC register; consumes the
//  fetched instruction and PC+4, presents them to the decode stage.
//  Honours the same load-use hold signal as the PC register, and supports a branch flush.
//  Keeps saturating counters of stall and flush cycles for performance debug.
// PARAMETERS
//  WIDTH  32            datapath width of PC+4 and instruction
//  NOP    32'h00000000  instruction word inserted on flush (sll $0,$0,0)
//  CNT_W  16            width of stall/flush counters
// PORTS
//  clk         in   1      rising-edge clock
//  clrn        in   1      asynchronous active-low reset
//  LOADDEPEEN  in   1      1 = load new stage contents; 0 = load-use hold
//  flush       in   1      1 = squash fetched instr (branch/jump taken in ID)
//  pc4_in      in   WIDTH  PC+4 of fetched instruction
//  inst_in     in   WIDTH  fetched instruction word
//  pc4_out     out  WIDTH  registered PC+4 to ID
//  inst_out    out  WIDTH  registered instruction to ID
//  valid_out   out  1      1 = inst_out is a real instruction, 0 = bubble
//  stall_cnt   out  CNT_W  cycles held by LOADDEPEEN=0 (saturating)
//  flush_cnt   out  CNT_W  cycles with flush=1 (saturating)
// BEHAVIOUR
//  - Reset (clrn=0, asynchronous, any time incl. mid-stall): pc4_out=0, inst_out=NOP,
//    valid_out=0, stall_cnt=0, flush_cnt=0. Outputs hold these until first clk edge
//    after clrn returns high.
//  - All updates on posedge clk; latency 1 cycle input->output. No combinational path
//    from any input to any output.
//  - Priority per edge (highest first):
//    1 flush=1: inst_out<=NOP, pc4_out<=pc4_in, valid_out<=0, flush_cnt+=1.
//      Flush overrides LOADDEPEEN=0; stall_cnt does NOT increment that cycle.
//    2 LOADDEPEEN=0: pc4_out, inst_out, valid_out hold; stall_cnt+=1.
//    3 otherwise: pc4_out<=pc4_in, inst_out<=inst_in, valid_out<=1.
//  - Counters: unsigned CNT_W bits, saturate at all-ones (no wrap); only reset clears.
//  - Back-to-back stalls: contents held indefinitely; stall_cnt increments every cycle.
//  - Stall release: first edge with LOADDEPEEN=1 loads inputs (held PC register
//    presents the same pc4_in, so no instruction is lost or duplicated).
//  - Inputs X while LOADDEPEEN=0 and flush=0 must not disturb outputs.
// STRUCTURE
//  - Shared package cpu_pkg: WORD_W=32, NOP_INST=32'h0000_0000, PERF_CNT_W=16;
//    parameters default from these.
//  - One sub-module: sat_counter #(W) (clk, clrn, inc, cnt) instantiated twice
//    (stall, flush); increments when inc=1, holds at 2^W-1.
//  - Pipeline register body written inline; no FSM beyond valid bit.
// TESTING
//  1 Reset: clrn=0 with inputs active -> pc4_out=0, inst_out=0, valid_out=0, counters 0,
//    asynchronously (before next clk edge).
//  2 Pass-through: LOADDEPEEN=1, flush=0, pc4_in=0x4, inst_in=0x8C010000 -> next edge
//    pc4_out=0x4, inst_out=0x8C010000, valid_out=1.
//  3 Load-use hold: LOADDEPEEN=0 for 3 cycles while inputs change -> outputs keep prior
//    values, stall_cnt=3; release -> new inputs appear one edge later.
//  4 Flush vs stall: flush=1 and LOADDEPEEN=0 same edge, pc4_in=0x20 -> inst_out=NOP,
//    pc4_out=0x20, valid_out=0, flush_cnt+1, stall_cnt unchanged.
//  5 Saturation: CNT_W=4, hold LOADDEPEEN=0 for 20 cycles -> stall_cnt stops at 15.
//  6 Reset mid-stall: clrn pulsed low during stall with stall_cnt=5 -> all outputs and
//    counters 0 immediately; next LOADDEPEEN=1 edge loads normally, valid_out=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the CPU pipeline blocks.
//
//   WORD_W      datapath width of instruction words and PC values
//   NOP_INST    instruction word used as a pipeline bubble (sll $0,$0,0)
//   PERF_CNT_W  width of the performance-debug event counters
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int          WORD_W     = 32;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam int          PERF_CNT_W = 16;

endpackage : cpu_pkg

// File: rtl/if_id_pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Unsigned event counter that counts up by one on every clock edge where
//   inc is high and sticks at all-ones instead of wrapping. Only reset
//   clears it.
//
//   Ports
//     clk   in   1   rising-edge clock
//     clrn  in   1   asynchronous active-low reset, clears the count
//     inc   in   1   count this cycle
//     cnt   out  W   current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;
    logic         w_at_max;

    // All-ones means saturated: further increments are dropped.
    assign w_at_max = &r_cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt <= '0;
        end else if (inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter

// File: rtl/if_id_pipe.sv
// -----------------------------------------------------------------------------
// if_id_pipe
//   IF/ID pipeline register. Captures the fetched instruction and its PC+4
//   and presents them to the decode stage one clock later.
//
//   - flush squashes the fetched instruction into a NOP bubble (branch or
//     jump resolved taken in ID). It wins over a load-use hold.
//   - LOADDEPEEN=0 holds the current contents (load-use hazard); the PC
//     register is held by the same signal, so on release the same pc4_in is
//     presented again and nothing is lost or duplicated.
//   - Two saturating counters record hold cycles and flush cycles.
//
//   Ports
//     clk         in   1      rising-edge clock
//     clrn        in   1      asynchronous active-low reset
//     LOADDEPEEN  in   1      1 = load new contents, 0 = hold
//     flush       in   1      1 = insert bubble instead of inst_in
//     pc4_in      in   WIDTH  PC+4 of the fetched instruction
//     inst_in     in   WIDTH  fetched instruction word
//     pc4_out     out  WIDTH  registered PC+4
//     inst_out    out  WIDTH  registered instruction
//     valid_out   out  1      1 = real instruction, 0 = bubble
//     stall_cnt   out  CNT_W  hold cycles (saturating)
//     flush_cnt   out  CNT_W  flush cycles (saturating)
//
//   All outputs come straight from flops; there is no combinational path
//   from any input to any output.
// -----------------------------------------------------------------------------
module if_id_pipe
    import cpu_pkg::*;
#(
    parameter int               WIDTH = WORD_W,
    parameter logic [WIDTH-1:0] NOP   = NOP_INST[WIDTH-1:0],
    parameter int               CNT_W = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             LOADDEPEEN,
    input  logic             flush,
    input  logic [WIDTH-1:0] pc4_in,
    input  logic [WIDTH-1:0] inst_in,
    output logic [WIDTH-1:0] pc4_out,
    output logic [WIDTH-1:0] inst_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [WIDTH-1:0] r_pc4;
    logic [WIDTH-1:0] r_inst;
    logic             r_valid;

    logic w_stall_inc;
    logic w_flush_inc;

    // ------------------------------------------------------------------
    // Stage register. Flush is tested first so that a taken branch still
    // squashes the slot even while a load-use hold is asserted. On a hold
    // nothing is assigned, so X on the data inputs cannot leak through.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc4   <= '0;
            r_inst  <= NOP;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_pc4   <= pc4_in;
            r_inst  <= NOP;
            r_valid <= 1'b0;
        end else if (LOADDEPEEN) begin
            r_pc4   <= pc4_in;
            r_inst  <= inst_in;
            r_valid <= 1'b1;
        end
    end

    assign pc4_out   = r_pc4;
    assign inst_out  = r_inst;
    assign valid_out = r_valid;

    // A cycle that is both flushed and held counts only as a flush, since
    // the flush is what actually happened to the register contents.
    assign w_stall_inc = !flush && !LOADDEPEEN;
    assign w_flush_inc = flush;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clrn (clrn),
        .inc  (w_stall_inc),
        .cnt  (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .clrn (clrn),
        .inc  (w_flush_inc),
        .cnt  (flush_cnt)
    );

endmodule : if_id_pipe
